ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the pipelined datapath. It sits between the ID/EX latch and the memory stage. It resolves operand forwarding, selects ALU operands, and drives one internal `alu` instance. It registers the result and control fields into the EX/MEM pipeline register, with stall, flush and overflow-trap handling.

## Interface
- `FWD_EN`, default 1: 1 enables MEM/WB forwarding; 0 always uses register-file data.
- `clk`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the EX/MEM register.
- `flush`  in  1  load a bubble into EX/MEM.
- `idex_valid`  in  1  ID/EX holds a real instruction.
- `idex_aluop`  in  aluop_t  ALU operation.
- `idex_rdat1`, `idex_rdat2`  in  32  register-file reads of rs and rt.
- `idex_rs`, `idex_rt`, `idex_wsel`  in  5  source and destination register numbers.
- `idex_imm`  in  32  extended immediate.
- `idex_shamt`  in  5  shift amount.
- `idex_alusrc`  in  1  1 means portb takes the immediate.
- `idex_regwen`, `idex_memren`, `idex_memwen`, `idex_halt`, `idex_trapen`  in  1 each  control bits.
- `idex_npc`  in  32  PC+4.
- `mem_regwen`, `mem_wsel`, `mem_wdat`  in  1/5/32  MEM-stage writeback candidate.
- `wb_regwen`, `wb_wsel`, `wb_wdat`  in  1/5/32  WB-stage writeback candidate.
- `exmem_valid`, `exmem_regwen`, `exmem_memren`, `exmem_memwen`, `exmem_halt`, `exmem_ovf`  out  1 each  registered control bits.
- `exmem_aluout`, `exmem_stdat`, `exmem_npc`  out  32 each  registered result, store data and PC+4.
- `exmem_wsel`  out  5  registered destination register.

## Operation
- Forwarding applies per source register (rs → A, rt → B):
  - MEM match (`mem_regwen`, `mem_wsel` equal to the source, source ≠ 0) wins.
  - Otherwise a WB match applies.
  - Otherwise the register-file data is used.
  - Register 0 always reads 0.
- Operand selection:
  - Shift ops (ALU_SLL, ALU_SRL): porta = forwarded B, portb = zero-extended `idex_shamt`.
  - Otherwise porta = forwarded A; portb = `idex_imm` if `idex_alusrc`, else forwarded B.
- Store data: `exmem_stdat` = forwarded B, always.
- Overflow trap: if `idex_trapen` and the ALU reports overflow, latch `exmem_ovf`=1 and force `exmem_regwen`, `exmem_memren` and `exmem_memwen` to 0.
- Bubble: if `idex_valid`=0, load all control bits as 0. Data fields are don't-care but are loaded as 0.
- Register update priority: `flush` (load bubble) > `stall` (hold all fields) > normal load.
- `exmem_ovf` is cleared on the next non-stalled load of a non-trapping instruction.

## Timing
- Latency: ID/EX inputs and forwarding inputs sampled at edge N appear on the exmem outputs after edge N.
- The forwarding and ALU path is purely combinational within one cycle.
- Reset: while `nRST`=0, every exmem output is 0 immediately; there is no synchronous reset path.
- Reset deasserting mid-stall: the first edge with `nRST`=1 and `stall`=1 holds the zeros.
- Stall then unstall: the instruction presented on the first unstalled edge is loaded once. The stage does no internal replay.
- MEM and WB both match the same source: MEM data is used.

## Structure
- `cpu_types_pkg`:
  - `aluop_t` (existing).
  - `regbits_t` and `word_t`.
  - New `exmem_t` packed struct holding all exmem fields.
  - New `fwdsel_t` enum: FWD_RF, FWD_MEM, FWD_WB.
- Sub-module: one `alu` instance connected through `alu_if`; no other sub-modules.
- The forwarding decision is a local function used twice.

## Test plan
- Reset with `nRST`=0 mid-run → all exmem outputs 0 asynchronously, before any edge.
- ADD with rdat1=5, rdat2=7, no matches → next edge `exmem_aluout`=12, `exmem_regwen`=1.
- `idex_rs`=3, mem_wsel=3/wdat=100, wb_wsel=3/wdat=200, rdat1=1, ADD with imm 1 (alusrc=1) → `exmem_aluout`=101. With mem_regwen=0 → 201. With rs=0 → 1.
- SLL with rt data 0x1 and shamt 31 → `exmem_aluout`=0x80000000.
- Trapping ADD of 0x7FFFFFFF + 1 → `exmem_ovf`=1, `exmem_regwen`=0, `exmem_aluout`=0x80000000.
- Stall=1 for 3 cycles holds the previous outputs. Flush and stall asserted together → `exmem_valid`=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: ALU opcodes, register/word types, forwarding select, EX/MEM record.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_SLL,
      ALU_SRL,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU
   } aluop_t;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_MEM,
      FWD_WB
   } fwdsel_t;

   typedef struct packed {
      logic     valid;
      logic     regwen;
      logic     memren;
      logic     memwen;
      logic     halt;
      logic     ovf;
      word_t    aluout;
      word_t    stdat;
      word_t    npc;
      regbits_t wsel;
   } exmem_t;

   // Shift ops take their data from rt and their amount from the shamt field
   function automatic logic is_shift(input aluop_t op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the execute stage and its ALU.
// Latency: none (wires only).
// Backpressure: none (wires only).
interface alu_if;
   import cpu_types_pkg::*;

   word_t  porta;
   word_t  portb;
   aluop_t aluop;
   word_t  outport;
   logic   overflow;

   modport alu (input porta, input portb, input aluop, output outport, output overflow);
   modport ex  (output porta, output portb, output aluop, input outport, input overflow);
endinterface

// File: rtl/alu.sv
// 32-bit ALU: shifts, add/sub with signed overflow, logic ops, signed/unsigned set-less-than.
// Latency: purely combinational.
// Backpressure: none; result follows the operands within the cycle.
module alu
   import cpu_types_pkg::*;
(
   alu_if.alu aluif
);

   word_t sum;
   word_t diff;

   assign sum  = aluif.porta + aluif.portb;
   assign diff = aluif.porta - aluif.portb;

   // Select the result; overflow only means anything for signed add/sub
   always_comb begin
      aluif.outport  = '0;
      aluif.overflow = 1'b0;
      case (aluif.aluop)
         ALU_SLL:  aluif.outport = aluif.porta << aluif.portb[4:0];
         ALU_SRL:  aluif.outport = aluif.porta >> aluif.portb[4:0];
         ALU_ADD: begin
            aluif.outport  = sum;
            aluif.overflow = (aluif.porta[31] == aluif.portb[31]) && (sum[31] != aluif.porta[31]);
         end
         ALU_SUB: begin
            aluif.outport  = diff;
            aluif.overflow = (aluif.porta[31] != aluif.portb[31]) && (diff[31] != aluif.porta[31]);
         end
         ALU_AND:  aluif.outport = aluif.porta & aluif.portb;
         ALU_OR:   aluif.outport = aluif.porta | aluif.portb;
         ALU_XOR:  aluif.outport = aluif.porta ^ aluif.portb;
         ALU_NOR:  aluif.outport = ~(aluif.porta | aluif.portb);
         ALU_SLT:  aluif.outport = {31'b0, $signed(aluif.porta) < $signed(aluif.portb)};
         ALU_SLTU: aluif.outport = {31'b0, aluif.porta < aluif.portb};
         default:  aluif.outport = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU operand select, overflow trap, EX/MEM pipeline register.
// Latency: one cycle from ID/EX and forwarding inputs to the exmem outputs.
// Backpressure: stall holds every EX/MEM field; flush overrides stall and loads a bubble.
module ex_stage
   import cpu_types_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic     clk,
   input  logic     nRST,
   input  logic     stall,
   input  logic     flush,
   input  logic     idex_valid,
   input  aluop_t   idex_aluop,
   input  word_t    idex_rdat1,
   input  word_t    idex_rdat2,
   input  regbits_t idex_rs,
   input  regbits_t idex_rt,
   input  regbits_t idex_wsel,
   input  word_t    idex_imm,
   input  logic [4:0] idex_shamt,
   input  logic     idex_alusrc,
   input  logic     idex_regwen,
   input  logic     idex_memren,
   input  logic     idex_memwen,
   input  logic     idex_halt,
   input  logic     idex_trapen,
   input  word_t    idex_npc,
   input  logic     mem_regwen,
   input  regbits_t mem_wsel,
   input  word_t    mem_wdat,
   input  logic     wb_regwen,
   input  regbits_t wb_wsel,
   input  word_t    wb_wdat,
   output logic     exmem_valid,
   output logic     exmem_regwen,
   output logic     exmem_memren,
   output logic     exmem_memwen,
   output logic     exmem_halt,
   output logic     exmem_ovf,
   output word_t    exmem_aluout,
   output word_t    exmem_stdat,
   output word_t    exmem_npc,
   output regbits_t exmem_wsel
);

   alu_if aluif ();

   alu u_alu (
      .aluif (aluif)
   );

   fwdsel_t sel_a;
   fwdsel_t sel_b;
   word_t   fwd_a;
   word_t   fwd_b;
   logic    trap;
   exmem_t  nxt;
   exmem_t  q;

   // The younger MEM result beats WB; register 0 never forwards
   function automatic fwdsel_t fwd_select(
      input regbits_t src,
      input logic     m_wen,
      input regbits_t m_sel,
      input logic     w_wen,
      input regbits_t w_sel
   );
      fwdsel_t sel;
      sel = FWD_RF;
      if (FWD_EN && (src != '0)) begin
         if (m_wen && (m_sel == src))
            sel = FWD_MEM;
         else if (w_wen && (w_sel == src))
            sel = FWD_WB;
      end
      return sel;
   endfunction

   // Resolve the rs/rt values seen by this instruction; register 0 reads as zero
   always_comb begin
      sel_a = fwd_select(idex_rs, mem_regwen, mem_wsel, wb_regwen, wb_wsel);
      sel_b = fwd_select(idex_rt, mem_regwen, mem_wsel, wb_regwen, wb_wsel);
      case (sel_a)
         FWD_MEM: fwd_a = mem_wdat;
         FWD_WB:  fwd_a = wb_wdat;
         default: fwd_a = idex_rdat1;
      endcase
      case (sel_b)
         FWD_MEM: fwd_b = mem_wdat;
         FWD_WB:  fwd_b = wb_wdat;
         default: fwd_b = idex_rdat2;
      endcase
      if (idex_rs == '0)
         fwd_a = '0;
      if (idex_rt == '0)
         fwd_b = '0;
   end

   // Shifts operate on rt by shamt; everything else is rs against rt or the immediate
   always_comb begin
      aluif.aluop = idex_aluop;
      if (is_shift(idex_aluop)) begin
         aluif.porta = fwd_b;
         aluif.portb = {27'b0, idex_shamt};
      end else begin
         aluif.porta = fwd_a;
         aluif.portb = idex_alusrc ? idex_imm : fwd_b;
      end
   end

   // Build the next EX/MEM record; a trap kills all architectural side effects
   always_comb begin
      nxt  = '0;
      trap = 1'b0;
      if (idex_valid) begin
         trap       = idex_trapen & aluif.overflow;
         nxt.valid  = 1'b1;
         nxt.regwen = idex_regwen & ~trap;
         nxt.memren = idex_memren & ~trap;
         nxt.memwen = idex_memwen & ~trap;
         nxt.halt   = idex_halt;
         nxt.ovf    = trap;
         nxt.aluout = aluif.outport;
         nxt.stdat  = fwd_b;
         nxt.npc    = idex_npc;
         nxt.wsel   = idex_wsel;
      end
   end

   // EX/MEM register: flush beats stall, stall beats a normal load
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST)
         q <= '0;
      else if (flush)
         q <= '0;
      else if (!stall)
         q <= nxt;
   end

   assign exmem_valid  = q.valid;
   assign exmem_regwen = q.regwen;
   assign exmem_memren = q.memren;
   assign exmem_memwen = q.memwen;
   assign exmem_halt   = q.halt;
   assign exmem_ovf    = q.ovf;
   assign exmem_aluout = q.aluout;
   assign exmem_stdat  = q.stdat;
   assign exmem_npc    = q.npc;
   assign exmem_wsel   = q.wsel;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal cases plus randomized traffic against a behavioural model.
// Latency: model expects each loaded instruction on the outputs one edge after it is presented.
// Backpressure: random stall/flush exercised alongside the instruction stream.
module tb_ex_stage;
   import cpu_types_pkg::*;

   localparam bit     FWD_EN_TB = 1'b1;
   localparam longint MAXS      = 64'sd2147483647;
   localparam longint MINS      = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        nRST;
   logic        stall, flush, idex_valid;
   aluop_t      idex_aluop;
   logic [31:0] idex_rdat1, idex_rdat2, idex_imm, idex_npc;
   logic [4:0]  idex_rs, idex_rt, idex_wsel, idex_shamt;
   logic        idex_alusrc, idex_regwen, idex_memren, idex_memwen, idex_halt, idex_trapen;
   logic        mem_regwen, wb_regwen;
   logic [4:0]  mem_wsel, wb_wsel;
   logic [31:0] mem_wdat, wb_wdat;
   logic        exmem_valid, exmem_regwen, exmem_memren, exmem_memwen, exmem_halt, exmem_ovf;
   logic [31:0] exmem_aluout, exmem_stdat, exmem_npc;
   logic [4:0]  exmem_wsel;

   int checks = 0;
   int fails  = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic        valid, regwen, memren, memwen, halt, ovf;
      logic [31:0] aluout, stdat, npc;
      logic [4:0]  wsel;
   } exp_t;

   exp_t exp_q;

   ex_stage #(.FWD_EN(FWD_EN_TB)) dut (
      .clk(clk), .nRST(nRST), .stall(stall), .flush(flush),
      .idex_valid(idex_valid), .idex_aluop(idex_aluop),
      .idex_rdat1(idex_rdat1), .idex_rdat2(idex_rdat2),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_wsel(idex_wsel),
      .idex_imm(idex_imm), .idex_shamt(idex_shamt), .idex_alusrc(idex_alusrc),
      .idex_regwen(idex_regwen), .idex_memren(idex_memren), .idex_memwen(idex_memwen),
      .idex_halt(idex_halt), .idex_trapen(idex_trapen), .idex_npc(idex_npc),
      .mem_regwen(mem_regwen), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat),
      .wb_regwen(wb_regwen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
      .exmem_valid(exmem_valid), .exmem_regwen(exmem_regwen), .exmem_memren(exmem_memren),
      .exmem_memwen(exmem_memwen), .exmem_halt(exmem_halt), .exmem_ovf(exmem_ovf),
      .exmem_aluout(exmem_aluout), .exmem_stdat(exmem_stdat), .exmem_npc(exmem_npc),
      .exmem_wsel(exmem_wsel)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // Value an instruction sees for a source register: newest pending write wins
   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
      if (r == 5'd0) return 32'd0;
      if (FWD_EN_TB && mem_regwen && mem_wsel == r) return mem_wdat;
      if (FWD_EN_TB && wb_regwen && wb_wsel == r) return wb_wdat;
      return rf;
   endfunction

   // What the current ID/EX instruction should deposit into EX/MEM
   function automatic exp_t model_load();
      exp_t        e;
      logic [31:0] a, b, rhs, y;
      longint      wide;
      bit          v;
      e = '0;
      if (!idex_valid) return e;
      a    = operand(idex_rs, idex_rdat1);
      b    = operand(idex_rt, idex_rdat2);
      rhs  = idex_alusrc ? idex_imm : b;
      y    = 32'd0;
      v    = 1'b0;
      wide = 0;
      case (idex_aluop)
         ALU_SLL:  y = b << idex_shamt;
         ALU_SRL:  y = b >> idex_shamt;
         ALU_ADD: begin
            wide = longint'($signed(a)) + longint'($signed(rhs));
            y = wide[31:0];
            v = (wide > MAXS) || (wide < MINS);
         end
         ALU_SUB: begin
            wide = longint'($signed(a)) - longint'($signed(rhs));
            y = wide[31:0];
            v = (wide > MAXS) || (wide < MINS);
         end
         ALU_AND:  y = a & rhs;
         ALU_OR:   y = a | rhs;
         ALU_XOR:  y = a ^ rhs;
         ALU_NOR:  y = ~(a | rhs);
         ALU_SLT:  y = ($signed(a) < $signed(rhs)) ? 32'd1 : 32'd0;
         ALU_SLTU: y = (a < rhs) ? 32'd1 : 32'd0;
         default:  y = 32'd0;
      endcase
      e.valid  = 1'b1;
      e.ovf    = idex_trapen && v;
      e.regwen = idex_regwen && !e.ovf;
      e.memren = idex_memren && !e.ovf;
      e.memwen = idex_memwen && !e.ovf;
      e.halt   = idex_halt;
      e.aluout = y;
      e.stdat  = b;
      e.npc    = idex_npc;
      e.wsel   = idex_wsel;
      return e;
   endfunction

   // Expected EX/MEM contents
   always @(posedge clk or negedge nRST) begin
      if (!nRST)       exp_q <= '0;
      else if (flush)  exp_q <= '0;
      else if (!stall) exp_q <= model_load();
   end

   // Compare every field on the falling edge, well away from the update edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_valid",  32'(exmem_valid),  32'(exp_q.valid));
         cmp("m_regwen", 32'(exmem_regwen), 32'(exp_q.regwen));
         cmp("m_memren", 32'(exmem_memren), 32'(exp_q.memren));
         cmp("m_memwen", 32'(exmem_memwen), 32'(exp_q.memwen));
         cmp("m_halt",   32'(exmem_halt),   32'(exp_q.halt));
         cmp("m_ovf",    32'(exmem_ovf),    32'(exp_q.ovf));
         cmp("m_aluout", exmem_aluout,      exp_q.aluout);
         cmp("m_stdat",  exmem_stdat,       exp_q.stdat);
         cmp("m_npc",    exmem_npc,         exp_q.npc);
         cmp("m_wsel",   32'(exmem_wsel),   32'(exp_q.wsel));
      end
   end

   task automatic idle();
      stall = 0; flush = 0; idex_valid = 0; idex_aluop = ALU_ADD;
      idex_rdat1 = 0; idex_rdat2 = 0; idex_rs = 0; idex_rt = 0; idex_wsel = 0;
      idex_imm = 0; idex_shamt = 0; idex_alusrc = 0; idex_regwen = 0; idex_memren = 0;
      idex_memwen = 0; idex_halt = 0; idex_trapen = 0; idex_npc = 0;
      mem_regwen = 0; mem_wsel = 0; mem_wdat = 0; wb_regwen = 0; wb_wsel = 0; wb_wdat = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic add_5_7();
      idle();
      idex_valid = 1; idex_aluop = ALU_ADD; idex_rs = 1; idex_rt = 2;
      idex_rdat1 = 5; idex_rdat2 = 7; idex_regwen = 1; idex_wsel = 4; idex_npc = 32'h104;
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return $urandom_range(0, 15);
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [4:0] rnd_reg();
      if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 3));
   endfunction

   initial begin
      idle();
      nRST = 0;
      #12;
      cmp("rst_valid", 32'(exmem_valid), 32'd0);
      cmp("rst_aluout", exmem_aluout, 32'd0);
      nRST = 1;
      chk_en = 1;

      // Plain add, no forwarding
      add_5_7();
      step();
      cmp("add_out", exmem_aluout, 32'd12);
      cmp("add_regwen", 32'(exmem_regwen), 32'd1);
      cmp("add_stdat", exmem_stdat, 32'd7);

      // Forwarding priority: MEM, then WB, then register 0
      idle();
      idex_valid = 1; idex_aluop = ALU_ADD; idex_rs = 3; idex_rt = 2; idex_rdat1 = 1;
      idex_rdat2 = 7; idex_alusrc = 1; idex_imm = 1; idex_regwen = 1;
      mem_regwen = 1; mem_wsel = 3; mem_wdat = 100;
      wb_regwen = 1; wb_wsel = 3; wb_wdat = 200;
      step();
      cmp("fwd_mem", exmem_aluout, 32'd101);
      mem_regwen = 0;
      step();
      cmp("fwd_wb", exmem_aluout, 32'd201);
      idex_rs = 0;
      step();
      cmp("fwd_r0", exmem_aluout, 32'd1);

      // Shifts take rt data and shamt
      idle();
      idex_valid = 1; idex_aluop = ALU_SLL; idex_rs = 6; idex_rdat1 = 32'hFFFF;
      idex_rt = 5; idex_rdat2 = 1; idex_shamt = 31;
      step();
      cmp("sll31", exmem_aluout, 32'h80000000);
      idex_aluop = ALU_SRL; idex_shamt = 4;
      mem_regwen = 1; mem_wsel = 5; mem_wdat = 32'h80000000;
      step();
      cmp("srl_fwd", exmem_aluout, 32'h08000000);
      cmp("srl_stdat", exmem_stdat, 32'h80000000);

      // Overflow without trap enable stays architectural
      idle();
      idex_valid = 1; idex_aluop = ALU_ADD; idex_rs = 1; idex_rdat1 = 32'h7FFFFFFF;
      idex_alusrc = 1; idex_imm = 1; idex_regwen = 1;
      step();
      cmp("notrap_ovf", 32'(exmem_ovf), 32'd0);
      cmp("notrap_regwen", 32'(exmem_regwen), 32'd1);

      // Trapping overflow
      idex_trapen = 1; idex_memwen = 1;
      step();
      cmp("trap_ovf", 32'(exmem_ovf), 32'd1);
      cmp("trap_regwen", 32'(exmem_regwen), 32'd0);
      cmp("trap_memwen", 32'(exmem_memwen), 32'd0);
      cmp("trap_out", exmem_aluout, 32'h80000000);

      // Stall holds for three cycles, then the next instruction loads once
      add_5_7();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("stall_out", exmem_aluout, 32'h80000000);
         cmp("stall_ovf", 32'(exmem_ovf), 32'd1);
      end
      stall = 0;
      step();
      cmp("unstall_out", exmem_aluout, 32'd12);
      cmp("unstall_ovf", 32'(exmem_ovf), 32'd0);

      // Flush beats stall
      stall = 1; flush = 1;
      step();
      cmp("flush_valid", 32'(exmem_valid), 32'd0);
      cmp("flush_out", exmem_aluout, 32'd0);

      // Async reset mid-run, then release while stalled
      add_5_7();
      step();
      cmp("pre_rst_out", exmem_aluout, 32'd12);
      nRST = 0;
      #1;
      cmp("async_rst_valid", 32'(exmem_valid), 32'd0);
      cmp("async_rst_out", exmem_aluout, 32'd0);
      stall = 1;
      #2;
      nRST = 1;
      step();
      cmp("rst_stall_valid", 32'(exmem_valid), 32'd0);
      cmp("rst_stall_out", exmem_aluout, 32'd0);
      stall = 0;
      step();
      cmp("post_rst_out", exmem_aluout, 32'd12);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom_range(0, 4) == 0);
         flush       = ($urandom_range(0, 11) == 0);
         idex_valid  = ($urandom_range(0, 6) != 0);
         idex_aluop  = aluop_t'(4'($urandom_range(0, 9)));
         idex_rdat1  = rnd_word();
         idex_rdat2  = rnd_word();
         idex_rs     = rnd_reg();
         idex_rt     = rnd_reg();
         idex_wsel   = 5'($urandom_range(0, 31));
         idex_imm    = rnd_word();
         idex_shamt  = 5'($urandom_range(0, 31));
         idex_alusrc = 1'($urandom_range(0, 1));
         idex_regwen = 1'($urandom_range(0, 1));
         idex_memren = 1'($urandom_range(0, 1));
         idex_memwen = 1'($urandom_range(0, 1));
         idex_halt   = ($urandom_range(0, 15) == 0);
         idex_trapen = 1'($urandom_range(0, 1));
         idex_npc    = $urandom();
         mem_regwen  = 1'($urandom_range(0, 1));
         mem_wsel    = rnd_reg();
         mem_wdat    = rnd_word();
         wb_regwen   = 1'($urandom_range(0, 1));
         wb_wsel     = rnd_reg();
         wb_wdat     = rnd_word();
         step();
      end

      idle();
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
